// File: rtl/mac_seq_pkg.sv
// Shared types, state encodings and sizing helpers for the sequential MAC.
package mac_seq_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_ACC  = 2'd2;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits
    function automatic int idx_w(input int n);
        int r;
        r = clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Number of BUS_W-wide slices in the accumulator
    function automatic int slice_count(input int acc_w, input int bus_w);
        return acc_w / bus_w;
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Operand handshake, result status and slice-access control for the MAC.
// The shared tri-state slice bus itself stays a plain inout on the top.
interface mac_seq_if #(
    parameter int DATA_W = 8,
    parameter int BUS_W  = 8,
    parameter int SEL_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_clr;
    logic              done;
    logic [BUS_W-1:0]  out_low;
    logic              io_drive;
    logic [SEL_W-1:0]  io_sel;
    logic              load_ext;
    logic              sat_flag;

    modport master (
        output in_valid, in_a, in_b, in_clr, io_drive, io_sel, load_ext,
        input  in_ready, done, out_low, sat_flag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_clr, io_drive, io_sel, load_ext,
        output in_ready, done, out_low, sat_flag
    );
endinterface

// File: rtl/mac_seq_mul.sv
// Shift-add multiplier core: one multiplier bit per cycle, always DATA_W
// iterations. prod_valid_o pulses the cycle after the last iteration and
// prod_o holds its value until the next start.
module mac_seq_mul
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  last_o,
    output logic                  prod_valid_o,
    output logic [2*DATA_W-1:0]   prod_o
);
    localparam int CNT_W = idx_w(DATA_W);

    logic [2*DATA_W-1:0] a_sh_q, a_sh_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                pv_q, pv_d;

    assign last_o       = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign busy_o       = busy_q;
    assign prod_valid_o = pv_q;
    assign prod_o       = prod_q;

    // Next-state: load on start, otherwise one shift-add step while busy
    always_comb begin
        a_sh_d = a_sh_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        pv_d   = 1'b0;
        if (start_i) begin
            a_sh_d = {{DATA_W{1'b0}}, a_i};
            b_d    = b_i;
            prod_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (b_q[0]) prod_d = prod_q + a_sh_q;
            a_sh_d = a_sh_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_o) begin
                busy_d = 1'b0;
                pv_d   = 1'b1;
            end
        end
    end

    // Control registers: cleared by reset so an in-flight multiply is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            pv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            pv_q   <= pv_d;
        end
    end

    // Datapath registers: only meaningful after a start, so no reset needed
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_q    <= b_d;
        prod_q <= prod_d;
    end

endmodule

// File: rtl/mac_seq_param.sv
// Parametrised unsigned multiply-accumulate with a sequential multiplier and
// slice-wise read/preload of the accumulator over a shared tri-state bus.
// Optional feature macro: MAC_SAT_EN (saturating accumulate + sticky sat_flag).
module mac_seq_param
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int BUS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    mac_seq_if.slave         bus_if,
    inout  wire [BUS_W-1:0]  io_bus
);
    localparam int NSLICE = slice_count(ACC_W, BUS_W);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                clr_q, clr_d;
    logic                accept;
    logic                load_en;
    logic                sel_ok;
    logic [BUS_W-1:0]    slice_rd;
    logic [ACC_W-1:0]    prod_ext;

    logic                mul_busy;
    logic                mul_last;
    logic                mul_prod_valid;
    logic [2*DATA_W-1:0] mul_prod;

    mac_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start_i      (accept),
        .a_i          (bus_if.in_a),
        .b_i          (bus_if.in_b),
        .busy_o       (mul_busy),
        .last_o       (mul_last),
        .prod_valid_o (mul_prod_valid),
        .prod_o       (mul_prod)
    );

    assign bus_if.in_ready = (state_q == ST_IDLE) && !mul_busy;
    assign accept          = bus_if.in_valid && bus_if.in_ready;
    assign bus_if.done     = (state_q == ST_ACC);
    assign bus_if.out_low  = acc_q[BUS_W-1:0];
    assign prod_ext        = ACC_W'(mul_prod);
    assign sel_ok          = int'(bus_if.io_sel) < NSLICE;
    assign load_en         = bus_if.load_ext && !bus_if.io_drive &&
                             (state_q == ST_IDLE) && sel_ok;
    assign clr_d           = accept ? bus_if.in_clr : clr_q;

    // Slice read mux; an out-of-range index reads as zero
    always_comb begin
        slice_rd = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (int'(bus_if.io_sel) == k) slice_rd = acc_q[k*BUS_W +: BUS_W];
        end
    end

    assign io_bus = bus_if.io_drive ? slice_rd : {BUS_W{1'bz}};

    // FSM next-state: IDLE -> MUL on accept, MUL -> ACC on the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_MUL;
            ST_MUL:  if (mul_last) state_d = ST_ACC;
            ST_ACC:                state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

`ifdef MAC_SAT_EN
    logic sat_q, sat_d;

    // Add with clamp to all ones; top bit of the result flags the clamp
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
        logic [ACC_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    // Accumulator update: ACC result, or an external slice preload in IDLE
    always_comb begin
        logic [ACC_W:0] r;
        r     = add_sat(acc_q, prod_ext);
        acc_d = acc_q;
        sat_d = sat_q;
        if (state_q == ST_ACC && mul_prod_valid) begin
            if (clr_q) begin
                acc_d = prod_ext;
                sat_d = 1'b0;
            end else begin
                acc_d = r[ACC_W-1:0];
                sat_d = sat_q | r[ACC_W];
            end
        end else if (load_en) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (int'(bus_if.io_sel) == k) acc_d[k*BUS_W +: BUS_W] = io_bus;
            end
        end
    end

    // Sticky saturation indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign bus_if.sat_flag = sat_q;
`else
    // Accumulator update: ACC result (wrapping), or an external slice preload in IDLE
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_ACC && mul_prod_valid) begin
            acc_d = clr_q ? prod_ext : acc_q + prod_ext;
        end else if (load_en) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (int'(bus_if.io_sel) == k) acc_d[k*BUS_W +: BUS_W] = io_bus;
            end
        end
    end

    assign bus_if.sat_flag = 1'b0;
`endif

    // State, accumulator and captured clear flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: tb/tb_mac_seq_param.sv
// Self-checking bench for mac_seq_param (DATA_W=8, ACC_W=32, BUS_W=8).
// Reference model: plain integer arithmetic on a 32-bit accumulator.
module tb_mac_seq_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    wire  [7:0] io_bus;
    logic [7:0] tb_drv = 8'h00;
    logic       tb_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] acc_m = 32'h0;
    bit          sat_m = 1'b0;

    assign io_bus = tb_en ? tb_drv : 8'bz;

    mac_seq_if #(.DATA_W(8), .BUS_W(8), .SEL_W(2)) mif ();

    mac_seq_param #(.DATA_W(8), .ACC_W(32), .BUS_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (mif),
        .io_bus (io_bus)
    );

    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    // Reference accumulate step
    task automatic model_op(input logic [7:0] a, input logic [7:0] b, input bit clr);
        logic [31:0] p;
        logic [32:0] s;
        p = 32'(a) * 32'(b);
        if (clr) begin
            acc_m = p;
            sat_m = 1'b0;
        end else begin
            s = {1'b0, acc_m} + {1'b0, p};
`ifdef MAC_SAT_EN
            if (s[32]) begin
                acc_m = 32'hFFFF_FFFF;
                sat_m = 1'b1;
            end else begin
                acc_m = s[31:0];
            end
`else
            acc_m = s[31:0];
`endif
        end
    endtask

    // Read all four slices over the bus; call right after a falling edge
    task automatic read_acc(output logic [31:0] v);
        tb_en = 1'b0;
        mif.io_drive = 1'b1;
        for (int s = 0; s < 4; s++) begin
            mif.io_sel = 2'(s);
            #1;
            v[s*8 +: 8] = io_bus;
        end
        mif.io_drive = 1'b0;
        mif.io_sel   = 2'd0;
    endtask

    // Wait (bounded) for done starting in cycle 1 of an op; lat=-1 if none
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (mif.done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One complete op; returns at the falling edge after done
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit clr,
                         output int lat);
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.in_a = a;
        mif.in_b = b;
        mif.in_clr = clr;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        wait_done(lat);
        @(negedge clk);
        model_op(a, b, clr);
    endtask

    // One-cycle slice preload from the bench side of the bus
    task automatic load_slice(input logic [1:0] sel, input logic [7:0] val);
        @(negedge clk);
        mif.io_drive = 1'b0;
        tb_en = 1'b1;
        tb_drv = val;
        mif.io_sel = sel;
        mif.load_ext = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.load_ext = 1'b0;
        tb_en = 1'b0;
        acc_m[sel*8 +: 8] = val;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", mif.in_ready); end
        checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mif.done); end
        checks++; if (mif.out_low !== 8'h00) begin errors++; $display("FAIL reset_out_low: got %h want 00", mif.out_low); end
        checks++; if (mif.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", mif.sat_flag); end
        rst = 1'b0;
        @(negedge clk);
        read_acc(v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h want 00000000", v); end
        acc_m = 32'h0;
        sat_m = 1'b0;
    endtask

    task automatic test_accumulate();
        int lat;
        logic [31:0] v;
        logic [7:0] av[3] = '{8'd3, 8'd2, 8'd100};
        logic [7:0] bv[3] = '{8'd4, 8'd5, 8'd2};
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], 1'b0, lat);
            checks++; if (lat != 9) begin errors++; $display("FAIL acc_latency[%0d]: got %0d want 9", i, lat); end
        end
        read_acc(v);
        checks++; if (v !== 32'd222) begin errors++; $display("FAIL acc_sum: got %0d want 222", v); end
        checks++; if (mif.out_low !== 8'hDE) begin errors++; $display("FAIL acc_out_low: got %h want de", mif.out_low); end
    endtask

    task automatic test_clear();
        int lat;
        logic [31:0] v;
        do_op(8'd255, 8'd255, 1'b1, lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL clr_latency: got %0d want 9", lat); end
        mif.io_drive = 1'b1;
        mif.io_sel = 2'd1;
        #1;
        checks++; if (io_bus !== 8'hFE) begin errors++; $display("FAIL clr_slice1: got %h want fe", io_bus); end
        mif.io_drive = 1'b0;
        read_acc(v);
        checks++; if (v !== 32'h0000_FE01) begin errors++; $display("FAIL clr_acc: got %h want 0000fe01", v); end
    endtask

    task automatic test_slice_load();
        int lat;
        logic [31:0] v;
        load_slice(2'd3, 8'hAA);
        read_acc(v);
        checks++; if (v !== 32'hAA00_FE01) begin errors++; $display("FAIL load_acc: got %h want aa00fe01", v); end
        mif.io_drive = 1'b1;
        mif.io_sel = 2'd3;
        #1;
        checks++; if (io_bus !== 8'hAA) begin errors++; $display("FAIL load_slice3: got %h want aa", io_bus); end
        // load_ext while the DUT owns the bus must be ignored
        @(negedge clk);
        mif.io_drive = 1'b1;
        mif.io_sel = 2'd0;
        mif.load_ext = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.load_ext = 1'b0;
        mif.io_drive = 1'b0;
        read_acc(v);
        checks++; if (v !== 32'hAA00_FE01) begin errors++; $display("FAIL load_drive_ignored: got %h want aa00fe01", v); end
        // load together with an accept: load lands first, op adds onto it
        @(negedge clk);
        tb_en = 1'b1;
        tb_drv = 8'h11;
        mif.io_sel = 2'd2;
        mif.load_ext = 1'b1;
        mif.in_valid = 1'b1;
        mif.in_a = 8'd1;
        mif.in_b = 8'd1;
        mif.in_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mif.load_ext = 1'b0;
        tb_en = 1'b0;
        mif.in_valid = 1'b0;
        wait_done(lat);
        @(negedge clk);
        acc_m[23:16] = 8'h11;
        model_op(8'd1, 8'd1, 1'b0);
        read_acc(v);
        checks++; if (v !== 32'hAA11_FE02) begin errors++; $display("FAIL load_with_accept: got %h want aa11fe02", v); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] v;
        for (int s = 0; s < 4; s++) load_slice(2'(s), 8'hFF);
        do_op(8'd1, 8'd1, 1'b0, lat);
        read_acc(v);
`ifdef MAC_SAT_EN
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_acc: got %h want ffffffff", v); end
        checks++; if (mif.sat_flag !== 1'b1) begin errors++; $display("FAIL ovf_sat: got %b want 1", mif.sat_flag); end
`else
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_acc: got %h want 00000000", v); end
        checks++; if (mif.sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat: got %b want 0", mif.sat_flag); end
`endif
        // A clear op restarts the accumulator and drops the sticky flag
        do_op(8'd2, 8'd3, 1'b1, lat);
        read_acc(v);
        checks++; if (v !== 32'd6) begin errors++; $display("FAIL ovf_clr_acc: got %h want 00000006", v); end
        checks++; if (mif.sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_clr_sat: got %b want 0", mif.sat_flag); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] v;
        int pulses;
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.in_a = 8'd9;
        mif.in_b = 8'd7;
        mif.in_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mif.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", mif.in_ready); end
        checks++; if (mif.out_low !== 8'h00) begin errors++; $display("FAIL rstmid_out_low: got %h want 00", mif.out_low); end
        rst = 1'b0;
        acc_m = 32'h0;
        sat_m = 1'b0;
        read_acc(v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_acc: got %h want 00000000", v); end
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (mif.done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int busy_bad;
        logic [31:0] v;
        logic [7:0] a0, b0, a1, b1;
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1 = 8'($urandom); b1 = 8'($urandom);
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.in_a = a0;
        mif.in_b = b0;
        mif.in_clr = 1'b1;
        @(posedge clk);
        busy_bad = 0;
        lat = -1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (mif.in_ready !== 1'b0) busy_bad++;
            if (mif.done === 1'b1 && lat < 0) lat = c;
            mif.in_a = 8'($urandom);
            mif.in_b = 8'($urandom);
            mif.in_clr = 1'($urandom);
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", busy_bad); end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_latency: got %0d want 9", lat); end
        @(negedge clk);
        model_op(a0, b0, 1'b1);
        checks++; if (mif.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_cycle10: got %b want 1", mif.in_ready); end
        read_acc(v);
        checks++; if (v !== acc_m) begin errors++; $display("FAIL b2b_first: got %h want %h", v, acc_m); end
        mif.in_a = a1;
        mif.in_b = b1;
        mif.in_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        wait_done(lat);
        @(negedge clk);
        model_op(a1, b1, 1'b0);
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d want 9", lat); end
        read_acc(v);
        checks++; if (v !== acc_m) begin errors++; $display("FAIL b2b_second: got %h want %h", v, acc_m); end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] v;
        logic [7:0] a, b;
        bit clr;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3) == 0) load_slice(2'($urandom_range(3)), 8'($urandom));
            if ($urandom_range(5) == 0) load_slice(2'd3, 8'hFF);
            a = 8'($urandom);
            b = 8'($urandom);
            clr = ($urandom_range(4) == 0);
            do_op(a, b, clr, lat);
            checks++; if (lat != 9) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 9", i, lat); end
            read_acc(v);
            checks++; if (v !== acc_m) begin errors++; $display("FAIL rnd_acc[%0d]: got %h want %h", i, v, acc_m); end
            checks++; if (mif.out_low !== acc_m[7:0]) begin errors++; $display("FAIL rnd_out_low[%0d]: got %h want %h", i, mif.out_low, acc_m[7:0]); end
            checks++; if (mif.sat_flag !== sat_m) begin errors++; $display("FAIL rnd_sat[%0d]: got %b want %b", i, mif.sat_flag, sat_m); end
        end
    endtask

    initial begin
        mif.in_valid = 1'b0;
        mif.in_a = 8'h00;
        mif.in_b = 8'h00;
        mif.in_clr = 1'b0;
        mif.io_drive = 1'b0;
        mif.io_sel = 2'd0;
        mif.load_ext = 1'b0;
        #3;
        test_reset();
        test_accumulate();
        test_clear();
        test_slice_load();
        test_overflow();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
